// File: rtl/results_loader_pkg.sv
// Shared constants for the results stream loader: ASCII separators, FSM
// encoding and the result word width used by the summing solver.
package results_loader_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DIGIT_W  = 5;
  localparam int unsigned MAX_DIGITS = WORD_W / NIBBLE_W;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DONE  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/results_loader_hex_char_decode.sv
// Combinational ASCII classifier: hex digit value plus hex/separator flags.
module hex_char_decode
  import results_loader_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_sep
);

  always_comb begin
    nibble = 4'd0;
    is_hex = 1'b0;
    is_sep = 1'b0;
    if (data >= 8'h30 && data <= 8'h39) begin
      nibble = 4'(data - 8'h30);
      is_hex = 1'b1;
    end else if (data >= 8'h61 && data <= 8'h66) begin
      nibble = 4'(data - 8'h57);
      is_hex = 1'b1;
    end else if (data >= 8'h41 && data <= 8'h46) begin
      nibble = 4'(data - 8'h37);
      is_hex = 1'b1;
    end else if (data == ASCII_LF || data == ASCII_CR || data == ASCII_SPACE) begin
      is_sep = 1'b1;
    end
  end

endmodule

// File: rtl/results_loader.sv
// Parses an ASCII hex results stream (one 64-bit word per line) and writes
// each word to an external results RAM, flagging malformed or oversized input.
module results_loader
  import results_loader_pkg::*;
#(
  parameter int unsigned ENTRY_COUNT = 468,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] entry_count,
  output logic              done,
  output logic              error
);

  state_t               state;
  logic [WORD_W-1:0]    acc;
  logic [DIGIT_W-1:0]   digit_cnt;

  logic [3:0]           nibble;
  logic                 is_hex;
  logic                 is_sep;

  logic [WORD_W-1:0]    acc_next;
  logic [DIGIT_W-1:0]   digit_cnt_next;
  logic                 bad_byte;
  logic                 terminate;
  logic                 overflow;
  logic                 accept;

  hex_char_decode u_decode (
    .data   (in_data),
    .nibble (nibble),
    .is_hex (is_hex),
    .is_sep (is_sep)
  );

  assign accept = in_valid && (state == S_RUN);

  // Effect of the current byte; in_last closes any pending word like a separator.
  always_comb begin
    acc_next       = acc;
    digit_cnt_next = digit_cnt;
    bad_byte       = 1'b0;
    if (is_hex) begin
      if (digit_cnt == DIGIT_W'(MAX_DIGITS)) begin
        bad_byte = 1'b1;
      end else begin
        acc_next       = {acc[WORD_W-NIBBLE_W-1:0], nibble};
        digit_cnt_next = digit_cnt + DIGIT_W'(1);
      end
    end else if (!is_sep) begin
      bad_byte = 1'b1;
    end
    terminate = !bad_byte && (digit_cnt_next != '0) && (is_sep || in_last);
    overflow  = terminate && (32'(entry_count) >= ENTRY_COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      in_ready    <= 1'b1;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      entry_count <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      acc         <= '0;
      digit_cnt   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        if (bad_byte || overflow) begin
          state    <= S_ERROR;
          in_ready <= 1'b0;
          error    <= 1'b1;
        end else begin
          if (terminate) begin
            wr_en       <= 1'b1;
            wr_addr     <= entry_count;
            wr_data     <= acc_next;
            entry_count <= entry_count + ADDR_W'(1);
            acc         <= '0;
            digit_cnt   <= '0;
          end else begin
            acc       <= acc_next;
            digit_cnt <= digit_cnt_next;
          end
          if (in_last) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
          end
        end
      end
    end
  end

endmodule
